cmp_trend_monitor: RTL
======================

Name: cmp_trend_monitor

Overview:
- Registered downstream consumer of the 2-bit comparator's one-hot result flags (a_gt_b, a_lt_b, a_eq_b).
- Classifies each valid comparison and counts results per class.
- Tracks the length of the current run of identical results and raises trend/alarm indications when a GT or LT run persists.
- Feeds status logic and the debug readout with saturating counters and a sticky protocol-error flag.

Parameters:
- CNT_W, 8, width of all counters and run_len; saturating maximum is 2^CNT_W-1.
- RUN_LEN, 4, run length at which a GT/LT run becomes a trend. Legal range is 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  comparator result valid this cycle.
- a_gt_b  input  1  comparator flag: a > b.
- a_lt_b  input  1  comparator flag: a < b.
- a_eq_b  input  1  comparator flag: a == b.
- clear  input  1  synchronous soft clear; same effect as rst.
- state  output  2  class of last accepted sample: 00 IDLE, 01 GT, 10 LT, 11 EQ.
- gt_count  output  CNT_W  accepted GT samples, saturating.
- lt_count  output  CNT_W  accepted LT samples, saturating.
- eq_count  output  CNT_W  accepted EQ samples, saturating.
- run_len  output  CNT_W  consecutive accepted samples of the current class, saturating.
- trend_up  output  1  level: state==GT and run_len>=RUN_LEN.
- trend_down  output  1  level: state==LT and run_len>=RUN_LEN.
- alarm  output  1  one-cycle pulse when a GT or LT run_len reaches exactly RUN_LEN.
- err_flag  output  1  sticky: an invalid flag code was presented while in_valid=1.

Behaviour:
- Clocking and reset:
  - Single clock domain; rst is synchronous and active-high.
  - rst=1 (or clear=1) at an edge sets every output to 0 and state to IDLE. This includes err_flag.
  - rst has priority over clear; clear has priority over in_valid. A sample presented alongside rst/clear is dropped.
- Sample acceptance:
  - A sample is accepted when in_valid=1 and exactly one flag is 1.
  - Invalid code with in_valid=1 (000, 011, 101, 110, 111):
    - err_flag is set and stays set until rst/clear.
    - All counters, run_len and state are unchanged.
    - alarm stays 0.
  - in_valid=0: flags are ignored and nothing changes. Idle gaps do not break a run.
- Latency: every output is registered and reflects an accepted sample on the cycle after the accepting edge (1-cycle latency). There is no combinational input-to-output path.
- FSM (state register = class of last accepted sample):
  - IDLE: any accepted sample moves to its class and sets run_len=1.
  - GT, LT, EQ: same-class sample keeps the state and increments run_len (saturating); different-class sample moves to the new class and sets run_len=1.
  - No transition back to IDLE except via rst/clear.
- Counters:
  - The class counter increments by 1 per accepted sample and holds at 2^CNT_W-1 (no wrap).
  - run_len saturates identically. Saturation of run_len does not retrigger alarm.
- Trend and alarm:
  - trend_up and trend_down are decoded from the registered state and run_len; they are mutually exclusive.
  - alarm=1 for exactly one cycle when an accepted GT/LT sample makes run_len go from RUN_LEN-1 to RUN_LEN. It is registered alongside run_len.
  - EQ runs never assert trend or alarm.
- Mid-operation reset: rst/clear during a run zeroes everything on that edge. The next accepted sample starts a fresh run at run_len=1.

Decomposition:
- Package cmp_mon_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_GT=2'b01, ST_LT=2'b10, ST_EQ=2'b11;
  - a cmp_state_t typedef;
  - the one-hot flag-code constants {gt,lt,eq} = 3'b100 / 3'b010 / 3'b001.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc, load1; output q), saturating at 2^W-1.
  - Instantiated four times: the gt, lt and eq counters, plus run_len.
  - For run_len, load1 forces q=1 on a class change.
- FSM, validity check, trend decode and alarm pulse logic live in the top module.

Test Plan:
- Reset: hold rst 2 cycles with random flags and in_valid=1 -> all outputs 0, state=00, err_flag=0.
- GT run (RUN_LEN=4): four valid 100 samples, with a 3-cycle in_valid=0 gap after the 2nd -> after the 4th: state=01, gt_count=4, run_len=4, trend_up=1, alarm high for exactly one cycle; a 5th GT gives run_len=5, alarm=0, trend_up still 1.
- Class change: three 100 samples then one 010 -> state=10, run_len=1, lt_count=1, trend_up=0, alarm never asserted.
- Invalid code: in_valid=1 with 110, then 000 -> err_flag=1, all counts and state unchanged; subsequent valid 001 is accepted (eq_count=1, state=11); clear=1 -> everything 0 including err_flag.
- Saturation (CNT_W=3, RUN_LEN=4): nine consecutive 001 samples -> eq_count=7, run_len=7, trend/alarm 0. Nine 010 samples after clear -> lt_count=7, alarm pulsed once only.
- Priority: clear=1 with in_valid=1, flags 100 -> sample dropped, gt_count=0, state=00. Same with rst mid GT run at run_len=3 -> next GT gives run_len=1.

Source files
------------

// File: rtl/cmp_mon_pkg.sv
// Shared encodings for the comparator trend monitor: state classes and
// one-hot flag codes {a_gt_b, a_lt_b, a_eq_b}.
package cmp_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GT   = 2'b01,
    ST_LT   = 2'b10,
    ST_EQ   = 2'b11
  } cmp_state_t;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_LT = 3'b010;
  localparam logic [2:0] FLAG_EQ = 3'b001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset/clear and a load-to-one
// input used to restart a run at length 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cmp_trend_monitor.sv
// Classifies valid comparator results, counts them per class, tracks the
// current run length and flags persistent GT/LT trends.
import cmp_mon_pkg::*;

module cmp_trend_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             clear,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] run_len,
  output logic             trend_up,
  output logic             trend_down,
  output logic             alarm,
  output logic             err_flag
);

  // Handshake: in_valid qualifies the flags for a single cycle; there is no
  // ready, every valid cycle is consumed (accepted or flagged as an error).

  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(RUN_LEN - 1);

  cmp_state_t state_q, state_d;
  cmp_state_t cls;
  logic [2:0] code;
  logic       accept, same_cls, alarm_d, bad_code;

  assign code = {a_gt_b, a_lt_b, a_eq_b};

  always_comb begin
    cls      = ST_IDLE;
    state_d  = state_q;
    accept   = 1'b0;
    same_cls = 1'b0;
    alarm_d  = 1'b0;
    bad_code = 1'b0;
    case (code)
      FLAG_GT: cls = ST_GT;
      FLAG_LT: cls = ST_LT;
      FLAG_EQ: cls = ST_EQ;
      default: cls = ST_IDLE;
    endcase
    accept   = in_valid && (cls != ST_IDLE);
    bad_code = in_valid && (cls == ST_IDLE);
    same_cls = accept && (cls == state_q);
    if (accept) state_d = cls;
    // Fires only on the RUN_LEN-1 -> RUN_LEN step, so saturation cannot retrigger it.
    alarm_d = same_cls && ((cls == ST_GT) || (cls == ST_LT)) && (run_len == RUN_M1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= ST_IDLE;
      alarm    <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm   <= alarm_d;
      if (bad_code) err_flag <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(accept && (cls == ST_GT)), .load1(1'b0), .q(gt_count)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(accept && (cls == ST_LT)), .load1(1'b0), .q(lt_count)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(accept && (cls == ST_EQ)), .load1(1'b0), .q(eq_count)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(same_cls), .load1(accept && !same_cls), .q(run_len)
  );

  assign state      = state_q;
  assign trend_up   = (state_q == ST_GT) && (run_len >= RUN_THR);
  assign trend_down = (state_q == ST_LT) && (run_len >= RUN_THR);

endmodule
